fixed_point_accumulator: RTL

- Sequential sign-magnitude accumulator that sits directly downstream of fixed_point_multiply.
- Consumes a stream of NUM_TERMS products (Q4.11 sign-magnitude, 16-bit) plus one bias term.
- Produces one saturated sign-magnitude sum per operation.
- Forms the neuron dot-product/bias stage feeding the activation stage.

---
 rtl/fixed_point_pkg.sv | 23 ++
 rtl/fixed_point_sm_convert.sv | 47 ++++
 rtl/fixed_point_accumulator.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fixed_point_pkg.sv
// Shared Q4.11 sign-magnitude definitions for the fixed-point neuron datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//   Holds the default word format, the largest representable magnitude,
//   handy Q4.11 constants and the accumulator FSM state encoding.
package fixed_point_pkg;

  localparam int BITSIZE = 16;
  localparam int FRAC    = 11;

  // Largest magnitude expressible in BITSIZE-bit sign-magnitude.
  localparam int MAG_MAX = (1 << (BITSIZE - 1)) - 1;

  localparam logic [BITSIZE-1:0] ONE     = 16'h0800;
  localparam logic [BITSIZE-1:0] NEG_ONE = 16'h8800;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fixed_point_sm_convert.sv
// Sign-magnitude <-> two's complement conversion with output saturation.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; both directions are evaluated every cycle.
//   sm_in  : sign-magnitude word to widen    -> tc_out : ACC_W two's complement
//   tc_in  : ACC_W two's complement value    -> sm_out : clipped sign-magnitude
//   sat    : tc_in fell outside +/-MAG_MAX and sm_out was clipped
module fixed_point_sm_convert
  import fixed_point_pkg::*;
#(
  parameter int BITSIZE = fixed_point_pkg::BITSIZE,
  parameter int ACC_W   = fixed_point_pkg::BITSIZE + 4
) (
  input  logic        [BITSIZE-1:0] sm_in,
  output logic signed [ACC_W-1:0]   tc_out,
  input  logic signed [ACC_W-1:0]   tc_in,
  output logic        [BITSIZE-1:0] sm_out,
  output logic                      sat
);

  localparam int MAG_W = BITSIZE - 1;
  localparam logic signed [ACC_W-1:0] POS_LIM = ACC_W'((1 << MAG_W) - 1);
  localparam logic signed [ACC_W-1:0] NEG_LIM = -POS_LIM;

  logic signed [ACC_W-1:0] mag_ext;
  logic        [MAG_W-1:0] abs_val;

  always_comb begin
    // Magnitude is zero-extended before negation, so 0x8000 maps to 0.
    mag_ext = {{(ACC_W - MAG_W){1'b0}}, sm_in[MAG_W-1:0]};
    tc_out  = sm_in[BITSIZE-1] ? -mag_ext : mag_ext;

    abs_val = MAG_W'(tc_in[ACC_W-1] ? -tc_in : tc_in);
    sm_out  = '0;
    sat     = 1'b0;
    if (tc_in > POS_LIM) begin
      sm_out = {1'b0, {MAG_W{1'b1}}};
      sat    = 1'b1;
    end else if (tc_in < NEG_LIM) begin
      sm_out = {1'b1, {MAG_W{1'b1}}};
      sat    = 1'b1;
    end else begin
      // Zero has a clear sign bit, so a zero sum never becomes 0x8000.
      sm_out = {tc_in[ACC_W-1], abs_val};
    end
  end

endmodule

// File: rtl/fixed_point_accumulator.sv
// Sequential sign-magnitude accumulator: bias + NUM_TERMS products, clipped once.
// Latency: out_valid rises on the edge after the last accepted term.
// Backpressure: in_ready only in ACCUM; result held in DONE until out_ready.
//   clk, rst             : rising-edge clock, synchronous active-high reset
//   start, bias          : begin an operation (IDLE only), bias captured with it
//   in_data/valid/ready  : product stream, one term per handshake
//   out_data/valid/ready : saturated sign-magnitude sum and its handshake
//   busy, sat_flag       : FSM not idle; result was clipped (with out_valid)
module fixed_point_accumulator
  import fixed_point_pkg::*;
#(
  parameter int BITSIZE   = fixed_point_pkg::BITSIZE,
  parameter int FRAC      = fixed_point_pkg::FRAC,
  parameter int NUM_TERMS = 8,
  parameter int GUARD     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BITSIZE-1:0] bias,
  input  logic [BITSIZE-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [BITSIZE-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               sat_flag
);

  localparam int ACC_W = BITSIZE + GUARD;
  localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

  // All terms share one Q format, so FRAC only needs to fit the word; the
  // guard bits must cover the bias plus every term without wrapping.
  if (NUM_TERMS < 1 || (NUM_TERMS + 1) > (1 << GUARD) || FRAC > BITSIZE - 1)
  begin : g_cfg_check
    $error("fixed_point_accumulator: invalid parameter combination");
  end

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic        [CNT_W-1:0] cnt;

  logic        [BITSIZE-1:0] conv_sm;
  logic signed [ACC_W-1:0]   conv_tc;
  logic signed [ACC_W-1:0]   sum;
  logic        [BITSIZE-1:0] res_sm;
  logic                      res_sat;

  // One converter serves all three uses: in IDLE its input is the bias being
  // captured, otherwise it is the incoming product; the result side always
  // sees acc + term, which is exactly what the last handshake registers.
  assign conv_sm = (state == IDLE) ? bias : in_data;
  assign sum     = acc + conv_tc;

  fixed_point_sm_convert #(
    .BITSIZE (BITSIZE),
    .ACC_W   (ACC_W)
  ) u_convert (
    .sm_in  (conv_sm),
    .tc_out (conv_tc),
    .tc_in  (sum),
    .sm_out (res_sm),
    .sat    (res_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= conv_tc;
            cnt      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= ACCUM;
          end
        end

        ACCUM: begin
          if (in_valid) begin
            acc <= sum;
            if (cnt == LAST_CNT) begin
              in_ready  <= 1'b0;
              out_data  <= res_sm;
              sat_flag  <= res_sat;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
